// File: rtl/multicycle_mem_responder.sv
`default_nettype none
// ============================================================================
// multicycle_mem_responder : unified I/D memory, fixed wait states, 1-cycle ready
// Rev 1.0
// ============================================================================
module multicycle_mem_responder #(
    parameter int    DEPTH       = 64,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [DEPTH];

    logic          w_bypass;
    logic          w_enter_resp;
    logic          w_acc_we;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic          w_fault;
    logic [AW-1:0] w_idx;
    logic          w_mem_we;

    // With zero wait states the access completes on the capture edge itself,
    // so the live inputs stand in for the not-yet-loaded capture registers.
    assign w_bypass     = (state_q == ST_IDLE);
    assign w_enter_resp = (state_q == ST_IDLE && req_i && WAIT_CYCLES == 0) ||
                          (state_q == ST_WAIT && cnt_q == 4'd1);
    assign w_acc_we     = w_bypass ? we_i    : we_q;
    assign w_acc_addr   = w_bypass ? addr_i  : addr_q;
    assign w_acc_wdata  = w_bypass ? wdata_i : wdata_q;
    assign w_fault      = (|w_acc_addr[1:0]) || (|w_acc_addr[31:AW+2]);
    assign w_idx        = w_acc_addr[AW+1:2];
    assign w_mem_we     = w_enter_resp && w_acc_we && !w_fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (w_enter_resp) begin
            err_d = w_fault;
            if (w_fault) begin
                rdata_d = '0;
            end else if (!w_acc_we) begin
                rdata_d = mem_q[w_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (state_q == ST_IDLE && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    // Contents survive reset; reset only blocks a write from landing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n && w_mem_we) begin
            mem_q[w_idx] <= w_acc_wdata;
        end
    end

    assign rdata_o = rdata_q;
    assign ready_o = (state_q == ST_RESP);
    assign err_o   = err_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule
`default_nettype wire
